// File: rtl/butterfly_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : butterfly_pkg
//  Description : Shared helpers for butterfly / Benes network stages:
//                switch control encodings and the lane-pairing function.
//  Revision    : 1.0 - initial release
// ============================================================================
package butterfly_pkg;

  localparam logic SWAP = 1'b1;
  localparam logic PASS = 1'b0;

  // Lower lane of switch k; its partner is pair_lo(k, stride) + stride.
  function automatic int pair_lo(input int k, input int stride);
    return (k / stride) * 2 * stride + (k % stride);
  endfunction

endpackage : butterfly_pkg
`default_nettype wire

// File: rtl/skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : skid_buffer
//  Description : Generic 2-entry valid/ready buffer. A main register drives
//                the output; a skid register absorbs one beat while the
//                registered in_rdy is still high during a stall.
//  Revision    : 1.0 - initial release
// ============================================================================
module skid_buffer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_data
);

  logic             r_main_val;
  logic             r_skid_val;
  logic             r_in_rdy;
  logic [WIDTH-1:0] r_main_data;
  logic [WIDTH-1:0] r_skid_data;

  logic w_accept;
  logic w_drain;
  logic w_main_val_nxt;
  logic w_skid_val_nxt;
  logic w_main_from_in;
  logic w_main_from_skid;
  logic w_skid_from_in;

  assign w_accept = in_val && r_in_rdy;
  assign w_drain  = r_main_val && out_rdy;

  // Route each beat: refill main from skid first, else new beat to main, else park in skid.
  always_comb begin
    w_main_val_nxt   = r_main_val;
    w_skid_val_nxt   = r_skid_val;
    w_main_from_in   = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_from_in   = 1'b0;
    if (w_drain && r_skid_val) begin
      // in_rdy is low whenever skid is full, so no accept can coincide here.
      w_main_from_skid = 1'b1;
      w_skid_val_nxt   = 1'b0;
    end else if (w_accept && (!r_main_val || w_drain)) begin
      w_main_from_in = 1'b1;
      w_main_val_nxt = 1'b1;
    end else if (w_accept) begin
      w_skid_from_in = 1'b1;
      w_skid_val_nxt = 1'b1;
    end else if (w_drain) begin
      w_main_val_nxt = 1'b0;
    end
  end

  // Valid flags and registered ready; ready tracks skid emptiness one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_val <= 1'b0;
      r_skid_val <= 1'b0;
      r_in_rdy   <= 1'b1;
    end else begin
      r_main_val <= w_main_val_nxt;
      r_skid_val <= w_skid_val_nxt;
      r_in_rdy   <= !w_skid_val_nxt;
    end
  end

  // Payload registers carry no reset; their valid flags qualify them.
  always_ff @(posedge clk) begin
    if (w_main_from_skid) begin
      r_main_data <= r_skid_data;
    end else if (w_main_from_in) begin
      r_main_data <= in_data;
    end
    if (w_skid_from_in) begin
      r_skid_data <= in_data;
    end
  end

  assign in_rdy   = r_in_rdy;
  assign out_val  = r_main_val;
  assign out_data = r_main_data;

endmodule : skid_buffer
`default_nettype wire

// File: rtl/switch_2_2.sv
`default_nettype none
// ============================================================================
//  Module      : switch_2_2
//  Description : 2x2 crossbar switch; passes or swaps two lanes.
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_2_2
  import butterfly_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             sel,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1
);

  // Select straight-through or crossed routing.
  always_comb begin
    out0 = in0;
    out1 = in1;
    if (sel == SWAP) begin
      out0 = in1;
      out1 = in0;
    end
  end

endmodule : switch_2_2
`default_nettype wire

// File: rtl/butterfly_stage_stream.sv
`default_nettype none
// ============================================================================
//  Module      : butterfly_stage_stream
//  Description : One column of 2x2 switches with configurable pairing stride,
//                followed by a 2-entry skid buffer and an output beat counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module butterfly_stage_stream
  import butterfly_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_INPUTS = 16,
  parameter int STRIDE     = 1,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_val,
  output logic                  in_rdy,
  input  logic [DATA_WIDTH-1:0] input_elements  [0:NUM_INPUTS-1],
  input  logic [NUM_INPUTS/2-1:0] ctrls,
  output logic                  out_val,
  input  logic                  out_rdy,
  output logic [DATA_WIDTH-1:0] output_elements [0:NUM_INPUTS-1],
  output logic [CNT_WIDTH-1:0]  beat_cnt
);

  localparam int NUM_SWITCHES = NUM_INPUTS / 2;
  localparam int c_payload_w  = DATA_WIDTH * NUM_INPUTS;

  if ((NUM_INPUTS < 2) || ((NUM_INPUTS & (NUM_INPUTS - 1)) != 0)) begin : g_chk_n
    $error("butterfly_stage_stream: NUM_INPUTS must be a power of two >= 2");
  end
  if ((STRIDE < 1) || ((STRIDE & (STRIDE - 1)) != 0)) begin : g_chk_s
    $error("butterfly_stage_stream: STRIDE must be a power of two >= 1");
  end
  if (STRIDE > NUM_SWITCHES) begin : g_chk_range
    $error("butterfly_stage_stream: STRIDE must not exceed NUM_INPUTS/2");
  end

  logic [DATA_WIDTH-1:0]  w_switched [0:NUM_INPUTS-1];
  logic [c_payload_w-1:0] w_in_payload;
  logic [c_payload_w-1:0] w_out_payload;
  logic                   w_out_val;
  logic [CNT_WIDTH-1:0]   r_beat_cnt;

  // Switching sits ahead of the buffer so each ctrls word travels with its own beat.
  for (genvar k = 0; k < NUM_SWITCHES; k++) begin : g_switch
    localparam int c_lo = pair_lo(k, STRIDE);
    localparam int c_hi = c_lo + STRIDE;
    switch_2_2 #(
      .WIDTH (DATA_WIDTH)
    ) u_switch (
      .in0  (input_elements[c_lo]),
      .in1  (input_elements[c_hi]),
      .sel  (ctrls[k]),
      .out0 (w_switched[c_lo]),
      .out1 (w_switched[c_hi])
    );
  end

  for (genvar l = 0; l < NUM_INPUTS; l++) begin : g_lane
    assign w_in_payload[l*DATA_WIDTH +: DATA_WIDTH] = w_switched[l];
    assign output_elements[l] = w_out_payload[l*DATA_WIDTH +: DATA_WIDTH];
  end

  skid_buffer #(
    .WIDTH (c_payload_w)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in_data  (w_in_payload),
    .out_val  (w_out_val),
    .out_rdy  (out_rdy),
    .out_data (w_out_payload)
  );

  // Count completed output handshakes; wraps naturally at full scale.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat_cnt <= '0;
    end else if (w_out_val && out_rdy) begin
      r_beat_cnt <= r_beat_cnt + CNT_WIDTH'(1);
    end
  end

  assign out_val  = w_out_val;
  assign beat_cnt = r_beat_cnt;

endmodule : butterfly_stage_stream
`default_nettype wire

// File: tb/tb_butterfly_stage_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_butterfly_stage_stream
//  Description : Directed self-checking bench for butterfly_stage_stream
//                (8 lanes, stride 2, 16-bit data, 4-bit beat counter).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_butterfly_stage_stream;

  localparam int DW = 16;
  localparam int N  = 8;
  localparam int S  = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_val;
  logic          in_rdy;
  logic [DW-1:0] input_elements  [0:N-1];
  logic [N/2-1:0] ctrls;
  logic          out_val;
  logic          out_rdy;
  logic [DW-1:0] output_elements [0:N-1];
  logic [CW-1:0] beat_cnt;

  int errors = 0;
  int checks = 0;

  butterfly_stage_stream #(
    .DATA_WIDTH (DW),
    .NUM_INPUTS (N),
    .STRIDE     (S),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_val          (in_val),
    .in_rdy          (in_rdy),
    .input_elements  (input_elements),
    .ctrls           (ctrls),
    .out_val         (out_val),
    .out_rdy         (out_rdy),
    .output_elements (output_elements),
    .beat_cnt        (beat_cnt)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are read 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW*N-1:0] obs, input logic [DW*N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Lanes carry base+lane so every lane of every beat is distinct.
  task automatic drive(input logic [DW-1:0] base, input logic [N/2-1:0] c);
    for (int l = 0; l < N; l++) input_elements[l] = base + DW'(l);
    ctrls = c;
  endtask

  function automatic logic [DW*N-1:0] pack_out();
    logic [DW*N-1:0] v;
    for (int l = 0; l < N; l++) v[l*DW +: DW] = output_elements[l];
    return v;
  endfunction

  // Reference: switch k pairs lanes lo=(k/S)*2S + k%S and lo+S.
  function automatic logic [DW*N-1:0] model(input logic [DW-1:0] base, input logic [N/2-1:0] c);
    logic [DW-1:0]   lane [0:N-1];
    logic [DW-1:0]   t;
    logic [DW*N-1:0] v;
    int lo;
    for (int l = 0; l < N; l++) lane[l] = base + DW'(l);
    for (int k = 0; k < N/2; k++) begin
      lo = (k / S) * 2 * S + (k % S);
      if (c[k]) begin
        t            = lane[lo];
        lane[lo]     = lane[lo + S];
        lane[lo + S] = t;
      end
    end
    for (int l = 0; l < N; l++) v[l*DW +: DW] = lane[l];
    return v;
  endfunction

  initial begin
    rst     = 1'b1;
    in_val  = 1'b0;
    out_rdy = 1'b0;
    drive(16'h0000, 4'b0000);
    step();
    step();
    rst = 1'b0;
    step();

    // Reset state
    chk("reset_out_val",  {127'd0, out_val}, 128'd0);
    chk("reset_in_rdy",   {127'd0, in_rdy},  128'd1);
    chk("reset_beat_cnt", {124'd0, beat_cnt}, 128'd0);

    // Single beat, lanes 0..7, ctrls 0101 -> [2,1,0,3,6,5,4,7]
    in_val  = 1'b1;
    out_rdy = 1'b1;
    drive(16'h0000, 4'b0101);
    step();
    in_val = 1'b0;
    chk("single_out_val", {127'd0, out_val}, 128'd1);
    chk("single_data", pack_out(),
        128'h0007_0004_0005_0006_0003_0000_0001_0002);
    chk("single_cnt_before", {124'd0, beat_cnt}, 128'd0);
    step();
    chk("single_cnt_after", {124'd0, beat_cnt}, 128'd1);
    chk("single_drained",   {127'd0, out_val},  128'd0);

    // 20 back-to-back beats with varying ctrls; counter wraps past 15
    for (int i = 0; i < 20; i++) begin
      in_val = 1'b1;
      drive(DW'(16'h0100 + i * 16), 4'(i * 5 + 3));
      step();
      chk($sformatf("b2b_val_%0d", i), {127'd0, out_val}, 128'd1);
      chk($sformatf("b2b_rdy_%0d", i), {127'd0, in_rdy},  128'd1);
      chk($sformatf("b2b_data_%0d", i), pack_out(),
          model(DW'(16'h0100 + i * 16), 4'(i * 5 + 3)));
      chk($sformatf("b2b_cnt_%0d", i), {124'd0, beat_cnt}, 128'((1 + i) % 16));
    end
    in_val = 1'b0;
    step();
    chk("b2b_cnt_final", {124'd0, beat_cnt}, 128'd5);
    chk("b2b_idle",      {127'd0, out_val},  128'd0);

    // Fill then stall: A to main, B to skid, C held off
    out_rdy = 1'b0;
    in_val  = 1'b1;
    drive(16'h0A00, 4'b1111);
    step();
    chk("stall_A_val",  {127'd0, out_val}, 128'd1);
    chk("stall_A_rdy",  {127'd0, in_rdy},  128'd1);
    chk("stall_A_data", pack_out(), model(16'h0A00, 4'b1111));
    drive(16'h0B00, 4'b0011);
    step();
    chk("stall_B_rdy",  {127'd0, in_rdy}, 128'd0);
    chk("stall_B_hold", pack_out(), model(16'h0A00, 4'b1111));
    drive(16'h0C00, 4'b1000);
    step();
    chk("stall_hold1_rdy",  {127'd0, in_rdy},  128'd0);
    chk("stall_hold1_val",  {127'd0, out_val}, 128'd1);
    chk("stall_hold1_data", pack_out(), model(16'h0A00, 4'b1111));
    step();
    chk("stall_hold2_data", pack_out(), model(16'h0A00, 4'b1111));
    chk("stall_hold2_cnt",  {124'd0, beat_cnt}, 128'd5);
    out_rdy = 1'b1;
    #1;
    chk("rdy_not_comb", {127'd0, in_rdy}, 128'd0);
    step();
    chk("drain_B_data", pack_out(), model(16'h0B00, 4'b0011));
    chk("drain_B_rdy",  {127'd0, in_rdy}, 128'd1);
    step();
    in_val = 1'b0;
    chk("drain_C_data", pack_out(), model(16'h0C00, 4'b1000));
    chk("drain_C_val",  {127'd0, out_val}, 128'd1);
    step();
    chk("drain_done_val", {127'd0, out_val},   128'd0);
    chk("drain_done_cnt", {124'd0, beat_cnt},  128'd8);

    // Reset with both registers full drops the buffered beats
    out_rdy = 1'b0;
    in_val  = 1'b1;
    drive(16'h0D00, 4'b0001);
    step();
    drive(16'h0E00, 4'b0010);
    step();
    chk("prerst_full", {127'd0, in_rdy}, 128'd0);
    in_val = 1'b0;
    rst    = 1'b1;
    step();
    rst = 1'b0;
    chk("postrst_val", {127'd0, out_val},  128'd0);
    chk("postrst_rdy", {127'd0, in_rdy},   128'd1);
    chk("postrst_cnt", {124'd0, beat_cnt}, 128'd0);
    out_rdy = 1'b1;
    step();
    step();
    chk("postrst_no_emit_val", {127'd0, out_val},  128'd0);
    chk("postrst_no_emit_cnt", {124'd0, beat_cnt}, 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_butterfly_stage_stream
`default_nettype wire
